// File: rtl/bsg_nonsynth_dpi_fifo_arbiter.sv
// bsg_nonsynth_dpi_fifo_arbiter
//   Shares one consumer valid/ready channel between els_p producer streams.
//   Round-robin with bursts of up to max_burst_p beats per grant. A beat that
//   is presented but stalled locks the grant until it is accepted. Producer
//   protocol is checked while locked (no retraction, stable data), and
//   accepted beats are counted per channel.
//
// Ports:
//   clk_i       clock
//   reset_n_i   asynchronous active-low reset
//   v_i         per-channel valid
//   data_i      per-channel data, channel k at [k*width_p +: width_p]
//   ready_o     per-channel ready, only the selected channel can be 1
//   v_o         valid to consumer
//   data_o      data to consumer
//   ready_i     consumer ready
//   grant_id_o  selected channel (meaningful when v_o=1)
//   error_o     sticky producer-protocol violation flag
//   beats_o     per-channel accepted-beat counters, channel k at [k*cnt_width_p +: cnt_width_p]
module bsg_nonsynth_dpi_fifo_arbiter #(
  parameter int els_p       = 4,
  parameter int width_p     = 32,
  parameter int max_burst_p = 4,
  parameter int cnt_width_p = 16,
  localparam int lg_els_lp  = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [els_p-1:0]             v_i,
  input  logic [els_p*width_p-1:0]     data_i,
  output logic [els_p-1:0]             ready_o,
  output logic                         v_o,
  output logic [width_p-1:0]           data_o,
  input  logic                         ready_i,
  output logic [lg_els_lp-1:0]         grant_id_o,
  output logic                         error_o,
  output logic [els_p*cnt_width_p-1:0] beats_o
);

  if (els_p < 2 || max_burst_p < 1) begin : g_param_check
    $fatal(1, "bsg_nonsynth_dpi_fifo_arbiter: need els_p >= 2 and max_burst_p >= 1");
  end

  localparam int bw_lp = (max_burst_p > 1) ? $clog2(max_burst_p) : 1;
  localparam int unsigned els_lp = els_p;

  typedef enum logic [1:0] {IDLE, BURST, LOCK} state_e;

  state_e                 state_r, state_n;
  logic [lg_els_lp-1:0]   gnt_r, gnt_n;
  logic [lg_els_lp-1:0]   rr_ptr_r, rr_ptr_n;
  logic [bw_lp-1:0]       burst_cnt_r, burst_cnt_n;
  logic [width_p-1:0]     data_lock_r, data_lock_n;
  logic [cnt_width_p-1:0] beats_r [els_p];

  logic [lg_els_lp-1:0]   sel, sel_rr;
  logic [width_p-1:0]     gnt_data;
  logic [bw_lp:0]         n;
  logic                   found, hold, retract, data_err, hs, cont_burst;
  int unsigned            idx;

  // Wrap by compare so non-power-of-2 channel counts wrap correctly.
  function automatic logic [lg_els_lp-1:0] inc_mod(input logic [lg_els_lp-1:0] x);
    return (int'(x) == els_p - 1) ? '0 : x + 1'b1;
  endfunction

  // Round-robin search starting at rr_ptr_r; falls back to rr_ptr_r if nobody is valid.
  always_comb begin
    sel_rr = rr_ptr_r;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < els_lp; i++) begin
      idx = int'(rr_ptr_r) + i;
      if (idx >= els_lp) idx = idx - els_lp;
      if (!found && v_i[lg_els_lp'(idx)]) begin
        sel_rr = lg_els_lp'(idx);
        found  = 1'b1;
      end
    end
  end

  // Selection and combinational datapath.
  always_comb begin
    retract  = (state_r == LOCK) && !v_i[gnt_r];
    hold     = ((state_r == LOCK) && !retract) || ((state_r == BURST) && v_i[gnt_r]);
    sel      = hold ? gnt_r : sel_rr;
    v_o      = v_i[sel];
    data_o   = data_i[sel*width_p +: width_p];
    ready_o  = '0;
    ready_o[sel] = ready_i;
    hs       = v_o & ready_i;
    gnt_data = data_i[gnt_r*width_p +: width_p];
    data_err = (state_r == LOCK) && !retract && (gnt_data != data_lock_r);
    grant_id_o = sel;
  end

  // Next-state logic.
  always_comb begin
    state_n     = state_r;
    gnt_n       = gnt_r;
    rr_ptr_n    = rr_ptr_r;
    burst_cnt_n = burst_cnt_r;
    data_lock_n = data_lock_r;
    cont_burst  = (state_r != IDLE) && (sel == gnt_r);
    n           = cont_burst ? ({1'b0, burst_cnt_r} + 1'b1) : (bw_lp+1)'(1);
    if (hs) begin
      if (n == (bw_lp+1)'(max_burst_p)) begin
        state_n     = IDLE;
        rr_ptr_n    = inc_mod(sel);
        burst_cnt_n = '0;
      end else begin
        state_n     = BURST;
        gnt_n       = sel;
        burst_cnt_n = n[bw_lp-1:0];
      end
    end else if (v_o) begin
      state_n     = LOCK;
      gnt_n       = sel;
      data_lock_n = data_o;
      burst_cnt_n = cont_burst ? burst_cnt_r : '0;
    end else begin
      // Covers retraction with no other requester: release and skip past the holder.
      state_n     = IDLE;
      burst_cnt_n = '0;
      if (state_r != IDLE) rr_ptr_n = inc_mod(gnt_r);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= IDLE;
      gnt_r       <= '0;
      rr_ptr_r    <= '0;
      burst_cnt_r <= '0;
      data_lock_r <= '0;
      error_o     <= 1'b0;
    end else begin
      state_r     <= state_n;
      gnt_r       <= gnt_n;
      rr_ptr_r    <= rr_ptr_n;
      burst_cnt_r <= burst_cnt_n;
      data_lock_r <= data_lock_n;
      error_o     <= error_o | retract | data_err;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned k = 0; k < els_lp; k++) beats_r[k] <= '0;
    end else if (hs) begin
      beats_r[sel] <= beats_r[sel] + 1'b1;
    end
  end

  for (genvar k = 0; k < els_p; k++) begin : g_beats
    assign beats_o[k*cnt_width_p +: cnt_width_p] = beats_r[k];
  end

endmodule
